// File: rtl/fpadd_arbiter_if.sv
// Bus bundle between the FP-adder arbiter and its requesters / external adder.
// slave  : arbiter side (takes requests and the adder result, drives grants,
//          responses and adder operands).
// master : requester/adder side (the mirror image).
// Signals: req_valid/ready/a/b/sub (request channel), resp_valid/ready/res/id
// (response channel), add_a/add_b/add_res (adder operands and sum), busy.
interface fpadd_arbiter_if #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDW   = $clog2(N_REQ)
);
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ-1:0]    req_ready;
    logic [32*N_REQ-1:0] req_a;
    logic [32*N_REQ-1:0] req_b;
    logic [N_REQ-1:0]    req_sub;
    logic [N_REQ-1:0]    resp_valid;
    logic [N_REQ-1:0]    resp_ready;
    logic [31:0]         resp_res;
    logic [IDW-1:0]      resp_id;
    logic [31:0]         add_a;
    logic [31:0]         add_b;
    logic [31:0]         add_res;
    logic                busy;

    modport slave (
        input  req_valid, req_a, req_b, req_sub, resp_ready, add_res,
        output req_ready, resp_valid, resp_res, resp_id, add_a, add_b, busy
    );

    modport master (
        output req_valid, req_a, req_b, req_sub, resp_ready, add_res,
        input  req_ready, resp_valid, resp_res, resp_id, add_a, add_b, busy
    );
endinterface

// File: rtl/fpadd_arbiter.sv
// Round-robin arbiter sharing one external combinational FP adder among
// N_REQ requesters. The winner's operands are registered onto add_a/add_b
// (b's sign flipped for subtract), held for LAT cycles, then the sum is
// captured and handed back to the winner with a valid/ready handshake.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous, active-high reset
//   bus  - fpadd_arbiter_if.slave: request/response channels, adder operands
//          and result, busy flag
module fpadd_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned LAT   = 1,
    parameter int unsigned IDW   = $clog2(N_REQ)
) (
    input  logic           clk,
    input  logic           rst,
    fpadd_arbiter_if.slave bus
);
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 4;
    localparam logic [CW-1:0]  CNT_LAST = CW'(LAT - 1);
    localparam logic [IDW-1:0] PTR_RST  = IDW'(N_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           r_state;
    logic [IDW-1:0]   r_ptr;
    logic [IDW-1:0]   r_resp_id;
    logic [CW-1:0]    r_cnt;
    logic [DW-1:0]    r_add_a;
    logic [DW-1:0]    r_add_b;
    logic [DW-1:0]    r_resp_res;
    logic [N_REQ-1:0] r_resp_valid;
    logic             r_busy;

    logic             w_gnt_found;
    logic [IDW-1:0]   w_gnt_idx;
    logic [N_REQ-1:0] w_req_ready;
    logic [DW-1:0]    w_gnt_a;
    logic [DW-1:0]    w_gnt_b;
    logic             w_gnt_sub;
    logic             w_resp_done;

    // Round-robin pick: scan ptr+1, ptr+2, ... ; iterating from the farthest
    // slot down lets the nearest valid requester overwrite the result.
    always_comb begin : arbitrate
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        for (int k = int'(N_REQ); k >= 1; k--) begin
            for (int i = 0; i < int'(N_REQ); i++) begin
                if (bus.req_valid[i] &&
                    (32'(i) == ((32'(r_ptr) + 32'(k)) % N_REQ))) begin
                    w_gnt_found = 1'b1;
                    w_gnt_idx   = IDW'(i);
                end
            end
        end
    end

    // Winner's operand lanes and the one-hot accept strobe.
    always_comb begin : operand_mux
        w_gnt_a     = '0;
        w_gnt_b     = '0;
        w_gnt_sub   = 1'b0;
        w_req_ready = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (w_gnt_idx == IDW'(i)) begin
                w_gnt_a   = bus.req_a[DW*i +: DW];
                w_gnt_b   = bus.req_b[DW*i +: DW];
                w_gnt_sub = bus.req_sub[i];
            end
            w_req_ready[i] = (r_state == S_IDLE) && w_gnt_found &&
                             (w_gnt_idx == IDW'(i));
        end
    end

    // resp_valid is one-hot to the owner, so masking resp_ready with it
    // ignores everyone else's ready.
    assign w_resp_done = (r_state == S_RESP) && (|(bus.resp_ready & r_resp_valid));

    // Control FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_ptr        <= PTR_RST;
            r_resp_id    <= '0;
            r_cnt        <= '0;
            r_add_a      <= '0;
            r_add_b      <= '0;
            r_resp_res   <= '0;
            r_resp_valid <= '0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_gnt_found) begin
                        r_add_a   <= w_gnt_a;
                        r_add_b   <= {w_gnt_b[DW-1] ^ w_gnt_sub, w_gnt_b[DW-2:0]};
                        r_resp_id <= w_gnt_idx;
                        r_ptr     <= w_gnt_idx;
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == CNT_LAST) begin
                        r_resp_res <= bus.add_res;
                        for (int i = 0; i < int'(N_REQ); i++) begin
                            r_resp_valid[i] <= (r_resp_id == IDW'(i));
                        end
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_RESP: begin
                    if (w_resp_done) begin
                        r_resp_valid <= '0;
                        r_busy       <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    r_resp_valid <= '0;
                    r_busy       <= 1'b0;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = w_req_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_res   = r_resp_res;
    assign bus.resp_id    = r_resp_id;
    assign bus.add_a      = r_add_a;
    assign bus.add_b      = r_add_b;
    assign bus.busy       = r_busy;
endmodule

// File: tb/tb_fpadd_arbiter.sv
// Self-checking bench for fpadd_arbiter: three instances (LAT=1, 3, 4) each
// paired with a lookup-table stand-in for the external FP adder.
module tb_fpadd_arbiter;
    localparam int unsigned N = 4;

    logic clk = 1'b0;
    logic rst1, rst3, rst4;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    fpadd_arbiter_if #(.N_REQ(N)) bus1 ();
    fpadd_arbiter_if #(.N_REQ(N)) bus3 ();
    fpadd_arbiter_if #(.N_REQ(N)) bus4 ();

    fpadd_arbiter #(.N_REQ(N), .LAT(1)) u_dut1 (.clk(clk), .rst(rst1), .bus(bus1));
    fpadd_arbiter #(.N_REQ(N), .LAT(3)) u_dut3 (.clk(clk), .rst(rst3), .bus(bus3));
    fpadd_arbiter #(.N_REQ(N), .LAT(4)) u_dut4 (.clk(clk), .rst(rst4), .bus(bus4));

    // Adder stand-in: exact IEEE sums for the operand pairs used here; any
    // other pair yields the integer sum so wrong routing still shows up.
    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        case ({a, b})
            {32'h3F800000, 32'h40000000}: r = 32'h40400000; // 1 + 2 = 3
            {32'h40400000, 32'hBF800000}: r = 32'h40000000; // 3 - 1 = 2
            {32'h40000000, 32'h40000000}: r = 32'h40800000; // 2 + 2 = 4
            {32'h40800000, 32'hC0000000}: r = 32'h40000000; // 4 - 2 = 2
            {32'h41200000, 32'h3F800000}: r = 32'h41300000; // 10 + 1 = 11
            {32'h41200000, 32'hC0400000}: r = 32'h40E00000; // 10 - 3 = 7
            {32'h40400000, 32'h40000000}: r = 32'h40A00000; // 3 + 2 = 5
            {32'h3F800000, 32'hFF800000}: r = 32'hFF800000; // 1 + -inf
            default:                      r = a + b;
        endcase
        return r;
    endfunction

    always_comb bus1.add_res = fp_add(bus1.add_a, bus1.add_b);
    always_comb bus3.add_res = fp_add(bus3.add_a, bus3.add_b);
    always_comb bus4.add_res = fp_add(bus4.add_a, bus4.add_b);

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] exp_b;
        logic [31:0] exp_res;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load one requester lane on bus1; other lanes get distinct junk and the
    // opposite sub bit so a wrong lane select is visible.
    task automatic set_req1(input int id, input logic [31:0] a, input logic [31:0] b,
                            input logic sub);
        logic [31:0] la [4];
        logic [31:0] lb [4];
        logic [3:0]  oh;
        for (int i = 0; i < 4; i++) begin
            la[i] = 32'hA5A50000 | 32'(i);
            lb[i] = 32'h5A5A0000 | 32'(i);
        end
        la[id] = a;
        lb[id] = b;
        oh = 4'(1) << id;
        bus1.req_a   = {la[3], la[2], la[1], la[0]};
        bus1.req_b   = {lb[3], lb[2], lb[1], lb[0]};
        bus1.req_sub = sub ? oh : ~oh;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] oh;
        int         gnt [8];
        int         at  [8];
        int         n_g;
        int         g;

        vecs[0] = '{0, 32'h3F800000, 32'h40000000, 1'b0, 32'h40000000, 32'h40400000};
        vecs[1] = '{2, 32'h40400000, 32'h3F800000, 1'b1, 32'hBF800000, 32'h40000000};
        vecs[2] = '{1, 32'h40000000, 32'h40000000, 1'b0, 32'h40000000, 32'h40800000};
        vecs[3] = '{3, 32'h40800000, 32'h40000000, 1'b1, 32'hC0000000, 32'h40000000};
        vecs[4] = '{2, 32'h41200000, 32'h40400000, 1'b1, 32'hC0400000, 32'h40E00000};
        vecs[5] = '{0, 32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 32'hFF800000};
        vecs[6] = '{3, 32'h40400000, 32'hC0000000, 1'b1, 32'h40000000, 32'h40A00000};

        bus1.req_valid = '0; bus1.resp_ready = '0; bus1.req_a = '0; bus1.req_b = '0; bus1.req_sub = '0;
        bus3.req_valid = '0; bus3.resp_ready = '0; bus3.req_a = '0; bus3.req_b = '0; bus3.req_sub = '0;
        bus4.req_valid = '0; bus4.resp_ready = '0; bus4.req_a = '0; bus4.req_b = '0; bus4.req_sub = '0;
        rst1 = 1'b1; rst3 = 1'b1; rst4 = 1'b1;
        tick();
        tick();
        rst1 = 1'b0; rst3 = 1'b0; rst4 = 1'b0;
        #1;

        // Reset state
        chk("rst_busy",       32'(bus1.busy), 32'd0);
        chk("rst_resp_valid", 32'(bus1.resp_valid), 32'd0);
        chk("rst_req_ready",  32'(bus1.req_ready), 32'd0);
        chk("rst_add_a",      bus1.add_a, 32'd0);
        chk("rst_add_b",      bus1.add_b, 32'd0);
        chk("rst_resp_res",   bus1.resp_res, 32'd0);
        chk("rst_resp_id",    32'(bus1.resp_id), 32'd0);

        // Single-requester transactions, LAT=1
        for (int v = 0; v < 7; v++) begin
            oh = 4'(1) << vecs[v].id;
            set_req1(vecs[v].id, vecs[v].a, vecs[v].b, vecs[v].sub);
            bus1.req_valid = oh;
            #1;
            chk("vec_req_ready", 32'(bus1.req_ready), 32'(oh));
            tick();
            chk("vec_wait_ready", 32'(bus1.req_ready), 32'd0);
            chk("vec_add_a",      bus1.add_a, vecs[v].a);
            chk("vec_add_b",      bus1.add_b, vecs[v].exp_b);
            chk("vec_wait_rv",    32'(bus1.resp_valid), 32'd0);
            bus1.req_valid = '0;
            tick();
            chk("vec_resp_valid", 32'(bus1.resp_valid), 32'(oh));
            chk("vec_resp_res",   bus1.resp_res, vecs[v].exp_res);
            chk("vec_resp_id",    32'(bus1.resp_id), 32'(vecs[v].id));
            bus1.resp_ready = 4'hF;
            tick();
            chk("vec_done_busy",  32'(bus1.busy), 32'd0);
            chk("vec_done_rv",    32'(bus1.resp_valid), 32'd0);
            bus1.resp_ready = '0;
        end

        // Round-robin with all requesters held valid, resp_ready tied high
        rst1 = 1'b1;
        tick();
        rst1 = 1'b0;
        set_req1(0, 32'h3F800000, 32'h40000000, 1'b0);
        bus1.req_valid  = 4'hF;
        bus1.resp_ready = 4'hF;
        #1;
        n_g = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (bus1.req_ready != 4'd0 && n_g < 8) begin
                g = 0;
                for (int i = 0; i < 4; i++) if (bus1.req_ready[i]) g = i;
                chk("rr_onehot", 32'($countones(bus1.req_ready)), 32'd1);
                gnt[n_g] = g;
                at[n_g]  = cyc;
                n_g++;
            end
            @(posedge clk);
            #2;
        end
        chk("rr_grant_count", 32'(n_g >= 5), 32'd1);
        for (int k = 0; k < 5 && k < n_g; k++) begin
            chk("rr_order", 32'(gnt[k]), 32'(k % 4));
            if (k > 0) chk("rr_spacing", 32'(at[k] - at[k-1]), 32'd3);
        end
        bus1.req_valid  = '0;
        bus1.resp_ready = '0;
        rst1 = 1'b1;
        tick();
        rst1 = 1'b0;

        // Response back-pressure: owner's ready low for 5 cycles
        set_req1(1, 32'h40000000, 32'h40000000, 1'b0);
        bus1.req_valid = 4'b0010;
        #1;
        tick();
        bus1.req_valid = 4'b1101;
        tick();
        bus1.resp_ready = 4'b1101;
        for (int s = 0; s < 5; s++) begin
            #1;
            chk("stall_rv",    32'(bus1.resp_valid), 32'h2);
            chk("stall_res",   bus1.resp_res, 32'h40800000);
            chk("stall_id",    32'(bus1.resp_id), 32'd1);
            chk("stall_ready", 32'(bus1.req_ready), 32'd0);
            chk("stall_busy",  32'(bus1.busy), 32'd1);
            tick();
        end
        bus1.req_valid  = 4'b0001;
        bus1.resp_ready = 4'b0010;
        tick();
        chk("stall_done_busy", 32'(bus1.busy), 32'd0);
        chk("stall_done_rv",   32'(bus1.resp_valid), 32'd0);
        chk("stall_next_gnt",  32'(bus1.req_ready), 32'h1);
        bus1.req_valid  = '0;
        bus1.resp_ready = '0;
        tick();

        // Reset mid-WAIT, LAT=4
        bus4.req_a   = {32'h0, 32'h40400000, 32'h0, 32'h41200000};
        bus4.req_b   = {4{32'h3F800000}};
        bus4.req_sub = '0;
        bus4.req_valid = 4'b0001;
        #1;
        chk("l4_req_ready", 32'(bus4.req_ready), 32'h1);
        tick();
        chk("l4_add_a", bus4.add_a, 32'h41200000);
        bus4.req_valid = 4'b0101;
        tick();
        tick();
        chk("l4_wait_busy", 32'(bus4.busy), 32'd1);
        chk("l4_wait_rv",   32'(bus4.resp_valid), 32'd0);
        rst4 = 1'b1;
        tick();
        rst4 = 1'b0;
        #1;
        chk("l4_rst_busy",  32'(bus4.busy), 32'd0);
        chk("l4_rst_rv",    32'(bus4.resp_valid), 32'd0);
        chk("l4_rst_add_a", bus4.add_a, 32'd0);
        chk("l4_rst_add_b", bus4.add_b, 32'd0);
        chk("l4_rst_tie",   32'(bus4.req_ready), 32'h1);
        bus4.req_valid  = '0;
        bus4.resp_ready = 4'hF;
        for (int s = 0; s < 6; s++) begin
            tick();
            chk("l4_no_resp", 32'(bus4.resp_valid), 32'd0);
            chk("l4_idle",    32'(bus4.busy), 32'd0);
        end
        bus4.resp_ready = '0;

        // Operand swap during WAIT, LAT=3
        bus3.req_a   = {32'h40800000, 96'h0};
        bus3.req_b   = {32'h40000000, 96'h0};
        bus3.req_sub = 4'b1000;
        bus3.req_valid = 4'b1000;
        #1;
        chk("l3_req_ready", 32'(bus3.req_ready), 32'h8);
        tick();
        chk("l3_add_b", bus3.add_b, 32'hC0000000);
        bus3.req_a   = {32'h41200000, 96'h0};
        bus3.req_b   = {32'h3F800000, 96'h0};
        bus3.req_sub = 4'b0000;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("l3_hold_a", bus3.add_a, 32'h40800000);
            chk("l3_hold_b", bus3.add_b, 32'hC0000000);
            if (k < 3) begin
                chk("l3_early_rv", 32'(bus3.resp_valid), 32'd0);
            end else begin
                chk("l3_rv",  32'(bus3.resp_valid), 32'h8);
                chk("l3_res", bus3.resp_res, 32'h40000000);
                chk("l3_id",  32'(bus3.resp_id), 32'd3);
            end
        end
        bus3.req_valid  = '0;
        bus3.resp_ready = 4'b1000;
        tick();
        chk("l3_done_busy", 32'(bus3.busy), 32'd0);
        bus3.resp_ready = '0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fpadd_arbiter.md
Name: fpadd_arbiter

Overview:
- Shares one single-precision FP adder datapath among N_REQ requesters.
- The adder is combinational and is instantiated outside this block.
- The block arbitrates round-robin, registers the winner's operands onto the adder inputs, and waits LAT cycles for the result to settle.
- It then captures the sum and returns it to the granted requester with a valid/ready handshake.
- It also applies subtract by flipping the sign of b.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- LAT, 1, cycles the adder input must be held stable before add_res is sampled (1..15).
- IDW, $clog2(N_REQ), width of the requester index.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; synchronous and active-high.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  per-requester request accept.
- req_a  in  32*N_REQ  operand a; requester i uses bits [32i+31:32i].
- req_b  in  32*N_REQ  operand b; same packing as req_a.
- req_sub  in  N_REQ  1 = compute a-b, 0 = compute a+b.
- resp_valid  out  N_REQ  result valid, one-hot to the granted requester.
- resp_ready  in  N_REQ  per-requester result accept.
- resp_res  out  32  result, shared by all requesters; meaningful only where resp_valid is set.
- resp_id  out  IDW  index of the requester owning the current result.
- add_a  out  32  registered operand a to the adder.
- add_b  out  32  registered operand b to the adder, sign already adjusted.
- add_res  in  32  combinational adder result.
- busy  out  1  high whenever state != IDLE.

Behaviour:

States: IDLE, WAIT, RESP (2-bit encoding).

Reset (rst high at a clk edge):
- state=IDLE; ptr=N_REQ-1, so requester 0 has first priority.
- add_a=0, add_b=0, resp_res=0, resp_id=0, cnt=0.
- resp_valid=0, req_ready=0, busy=0.
- Reset overrides every other event, including mid-WAIT and mid-RESP; any in-flight result is dropped and no response is issued.

Arbitration (combinational, IDLE only):
- grant = first i with req_valid[i]=1, scanning ptr+1, ptr+2, ... modulo N_REQ.
- req_ready[grant]=1; all other req_ready bits are 0.
- req_ready is 0 in WAIT and RESP.
- req_ready may depend combinationally on req_valid; requesters must not make req_valid depend on req_ready.

Accept edge (IDLE, req_valid[g]=1 and req_ready[g]=1):
- add_a <= req_a[g].
- add_b <= req_b[g], with bit 31 XORed with req_sub[g].
- resp_id <= g; ptr <= g; cnt <= 0; state <= WAIT.

WAIT:
- While cnt != LAT-1, cnt increments each cycle.
- When cnt == LAT-1, at that edge: resp_res <= add_res and state <= RESP.
- Result: resp_valid rises exactly LAT cycles after the accept edge.
- add_a and add_b are held stable from the accept edge until the next accept edge.

RESP:
- resp_valid[resp_id]=1; all other bits 0.
- resp_res and resp_id are held stable until the handshake.
- On resp_ready[resp_id]=1: state <= IDLE.
- resp_ready bits of other requesters are ignored.
- No new grant is issued in the handshake cycle. The earliest next accept is the following cycle, so peak throughput is one operation per LAT+2 cycles.

Fairness:
- Requesters that remain valid are served in rotating order g+1, g+2, ...
- Worst-case wait is (N_REQ-1) transactions.

Requester obligations:
- After asserting req_valid, a requester holds its operands and req_valid until req_ready.
- Dropping req_valid before acceptance is legal; that requester is simply not granted.

Other rules:
- The block does not interpret the FP data; it only flips the sign bit of b.
- NaN, infinity and denormal inputs pass through unchanged.
- cnt width is 4 bits. LAT=1 means WAIT lasts exactly one cycle.

Test Plan:
1. Reset, then req_valid=0001, a=0x3F800000 (1.0), b=0x40000000 (2.0), sub=0, LAT=1:
   - req_ready=0001 in the same cycle.
   - add_a=0x3F800000 and add_b=0x40000000 after the accept edge.
   - resp_valid=0001 one cycle later with resp_res=0x40400000 (3.0), resp_id=0.
2. Requester 2: a=0x40400000, b=0x3F800000, sub=1:
   - add_b=0xBF800000; resp_res=0x40000000 (2.0); resp_valid=0100.
3. All four requesters valid and held continuously, resp_ready tied high:
   - Grant order after reset is 0,1,2,3,0.
   - Accept edges are spaced exactly LAT+2=3 cycles apart.
4. resp_ready held low for 5 cycles in RESP:
   - resp_valid, resp_res and resp_id stay constant; req_ready=0000 throughout.
   - The result completes when resp_ready rises.
5. rst asserted during WAIT with LAT=4 (cnt=2):
   - Next cycle: state IDLE, busy=0, resp_valid=0000, add_a=add_b=0.
   - The dropped request is re-granted only if still valid, and requester 0 wins a tie.
6. LAT=3 with a requester swapping its operands during WAIT:
   - add_a and add_b are unchanged.
   - resp_valid rises exactly 3 cycles after the accept edge.
   - The captured value equals the adder output for the originally accepted operands.
